// File: rtl/inta_pkg.sv
// Shared types and constants for the INTA# cycle initiator.
// Holds the FSM state encoding and the pulse counts of the two bus modes.
package inta_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } inta_state_e;

  localparam logic [7:0] MCS80_CALL_OPCODE = 8'hCD;
  localparam int         PULSES_8086       = 2;
  localparam int         PULSES_MCS80      = 3;

  // Index of the final INTA# pulse for the mode latched at sequence start.
  function automatic logic [1:0] last_pulse_idx(input logic mode_8086);
    return mode_8086 ? 2'(PULSES_8086 - 1) : 2'(PULSES_MCS80 - 1);
  endfunction

endpackage

// File: rtl/int_synchronizer.sv
// Two-flop synchroniser for a level input arriving asynchronously to clock.
// Output lags the input by two rising edges; both flops clear on reset.
module int_synchronizer (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/inta_cycle_initiator.sv
// CPU-side INTA# sequencer: runs 2 (8086) or 3 (MCS-80) acknowledge pulses on INT,
// captures the PIC bytes and presents the vector / CALL target on a valid/ready port.
module inta_cycle_initiator
  import inta_pkg::*;
#(
  parameter int INTA_LOW_CYCLES = 4,
  parameter int INTA_GAP_CYCLES = 2,
  parameter int TIMER_W         = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        interrupt_to_cpu,
  input  logic        interrupt_enable,
  input  logic        u8086_or_mcs80_mode,
  input  logic [7:0]  data_bus_in,
  output logic        interrupt_acknowledge_n,
  output logic        vector_valid,
  input  logic        vector_ready,
  output logic [7:0]  vector_type,
  output logic [15:0] call_address,
  output logic        call_opcode_error,
  output logic        busy
);

  localparam logic [TIMER_W-1:0] LOW_LAST = TIMER_W'(INTA_LOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(INTA_GAP_CYCLES - 1);

  inta_state_e        state_q, state_d;
  logic [1:0]         pulse_idx_q, pulse_idx_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               mode_q, mode_d;
  logic [7:0]         byte0_q, byte0_d;
  logic [7:0]         byte1_q, byte1_d;
  logic [7:0]         byte2_q, byte2_d;
  logic [7:0]         vector_type_q, vector_type_d;
  logic [15:0]        call_address_q, call_address_d;
  logic               opcode_err_q, opcode_err_d;
  logic               vector_valid_q, vector_valid_d;
  logic               busy_q, busy_d;
  logic               int_sync;

  int_synchronizer u_int_sync (
    .clock   (clock),
    .reset   (reset),
    .async_i (interrupt_to_cpu),
    .sync_o  (int_sync)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      pulse_idx_q    <= 2'd0;
      timer_q        <= '0;
      mode_q         <= 1'b0;
      byte0_q        <= 8'h00;
      byte1_q        <= 8'h00;
      byte2_q        <= 8'h00;
      vector_type_q  <= 8'h00;
      call_address_q <= 16'h0000;
      opcode_err_q   <= 1'b0;
      vector_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pulse_idx_q    <= pulse_idx_d;
      timer_q        <= timer_d;
      mode_q         <= mode_d;
      byte0_q        <= byte0_d;
      byte1_q        <= byte1_d;
      byte2_q        <= byte2_d;
      vector_type_q  <= vector_type_d;
      call_address_q <= call_address_d;
      opcode_err_q   <= opcode_err_d;
      vector_valid_q <= vector_valid_d;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pulse_idx_d    = pulse_idx_q;
    timer_d        = timer_q;
    mode_d         = mode_q;
    byte0_d        = byte0_q;
    byte1_d        = byte1_q;
    byte2_d        = byte2_q;
    vector_type_d  = vector_type_q;
    call_address_d = call_address_q;
    opcode_err_d   = opcode_err_q;
    vector_valid_d = vector_valid_q;
    busy_d         = busy_q;

    case (state_q)
      IDLE: begin
        if (int_sync && interrupt_enable) begin
          mode_d       = u8086_or_mcs80_mode;
          pulse_idx_d  = 2'd0;
          timer_d      = '0;
          busy_d       = 1'b1;
          opcode_err_d = 1'b0;
          state_d      = LOW;
        end
      end

      LOW: begin
        // INTA# rises on the next edge, so this is the last cycle the PIC drives the bus.
        if (timer_q == LOW_LAST) begin
          timer_d = '0;
          case (pulse_idx_q)
            2'd0:    byte0_d = data_bus_in;
            2'd1:    byte1_d = data_bus_in;
            default: byte2_d = data_bus_in;
          endcase
          state_d = GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (pulse_idx_q == last_pulse_idx(mode_q)) begin
            vector_valid_d = 1'b1;
            if (mode_q) begin
              vector_type_d = byte1_q;
            end else begin
              call_address_d = {byte2_q, byte1_q};
              opcode_err_d   = (byte0_q != MCS80_CALL_OPCODE);
            end
            state_d = DONE;
          end else begin
            pulse_idx_d = pulse_idx_q + 2'd1;
            state_d     = LOW;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      DONE: begin
        if (vector_valid_q && vector_ready) begin
          vector_valid_d = 1'b0;
          busy_d         = 1'b0;
          state_d        = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Decoded straight from state so an async reset releases INTA# immediately.
  assign interrupt_acknowledge_n = (state_q != LOW);
  assign vector_valid            = vector_valid_q;
  assign vector_type             = vector_type_q;
  assign call_address            = call_address_q;
  assign call_opcode_error       = opcode_err_q;
  assign busy                    = busy_q;

endmodule

// File: doc/inta_cycle_initiator.md
Name: inta_cycle_initiator

Overview:
- CPU-side counterpart of the PIC control logic. Watches the PIC's INT output and runs the INTA# pulse train: two pulses in 8086 mode, three in MCS-80 mode.
- Samples the byte the PIC drives on each pulse and hands the assembled vector (8086 type) or CALL target (MCS-80) to the CPU-model/testbench core through a valid/ready handshake.
- Used as the bus-master model in PIC system benches and as the interrupt front end of the small CPU shell.

Parameters:
INTA_LOW_CYCLES, 4, clock cycles INTA# is held low per pulse (min 2)
INTA_GAP_CYCLES, 2, clock cycles INTA# is held high between and after pulses (min 1)
TIMER_W, 4, width of the pulse timer; must hold max(INTA_LOW_CYCLES, INTA_GAP_CYCLES)

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-high reset
interrupt_to_cpu  input  1  INT from the PIC, asynchronous to clock
interrupt_enable  input  1  CPU IF flag; gates sequence start only
u8086_or_mcs80_mode  input  1  1 = 8086 (2 pulses), 0 = MCS-80 (3 pulses)
data_bus_in  input  8  byte driven by the PIC while INTA# is low
interrupt_acknowledge_n  output  1  INTA# to the PIC
vector_valid  output  1  assembled result available
vector_ready  input  1  consumer accepts result
vector_type  output  8  8086 interrupt type (pulse-2 byte)
call_address  output  16  MCS-80 CALL target {pulse-3 byte, pulse-2 byte}
call_opcode_error  output  1  MCS-80 pulse-1 byte was not 8'hCD
busy  output  1  high from sequence start until result accepted

Behaviour:
- Reset (async): interrupt_acknowledge_n=1, vector_valid=0, vector_type=0, call_address=0, call_opcode_error=0, busy=0, state=IDLE, synchroniser flops=0. If reset asserts mid-pulse, INTA# rises immediately and no partial result is presented.
- INT passes through a 2-flop synchroniser (int_sync). Start latency is 2 cycles from the INT edge plus 1 cycle for the IDLE->LOW transition.
- States: IDLE, LOW, GAP, DONE.
- Internal registers:
  - pulse_idx: 2 bits.
  - timer: TIMER_W bits.
  - mode_q: mode latched at start.
  - byte0, byte1, byte2: capture registers.
- IDLE: busy=0. When int_sync=1 and interrupt_enable=1, do all of the following:
  - latch mode_q and set pulse_idx=0, timer=0, busy=1;
  - clear call_opcode_error;
  - go to LOW.
- LOW: interrupt_acknowledge_n=0 and timer increments.
  - On the cycle where timer==INTA_LOW_CYCLES-1, capture data_bus_in into byte[pulse_idx], clear timer and go to GAP.
  - INTA# goes high on the next edge, so the sample is taken on the last low cycle.
- GAP: interrupt_acknowledge_n=1 and timer increments. At timer==INTA_GAP_CYCLES-1, clear timer, then:
  - if pulse_idx is the last pulse (1 when mode_q=1, 2 when mode_q=0), go to DONE;
  - otherwise increment pulse_idx and go to LOW.
- DONE entry (one register update):
  - 8086: vector_type=byte1; call_address unchanged.
  - MCS-80: call_address={byte2,byte1}; call_opcode_error=(byte0!=8'hCD).
  - vector_valid=1.
- DONE: outputs stay stable while vector_valid=1 and vector_ready=0. When vector_valid && vector_ready, vector_valid=0, busy=0, go to IDLE. vector_ready is ignored in every other state.
- Boundary conditions:
  - INT deasserting after start does not abort. The sequence completes and the PIC supplies its spurious/IR7 byte.
  - interrupt_enable and u8086_or_mcs80_mode changes after start are ignored.
  - If INT is still high on return to IDLE, the next sequence starts on the following cycle (back-to-back).
  - In 8086 mode byte0 is captured but never used.
- Total sequence length: 8086 = 2*(LOW+GAP) cycles; MCS-80 = 3*(LOW+GAP) cycles.

Decomposition:
- Shared package inta_pkg: state enum (IDLE, LOW, GAP, DONE), constant MCS80_CALL_OPCODE=8'hCD, constant PULSES_8086=2, constant PULSES_MCS80=3.
- One natural sub-module, int_synchronizer: a 2-flop synchroniser with async reset. Reusable for the PIC IR inputs.
- Everything else stays in one FSM-plus-datapath body.

Test Plan:
- 8086 mode, defaults. PIC model drives 8'hFF on pulse 1 and 8'h4A on pulse 2; INT raised at t0 -> exactly 2 INTA# low pulses, each 4 cycles, 2-cycle gaps; vector_type=8'h4A; vector_valid held until vector_ready, which is asserted 5 cycles later.
- MCS-80 mode. Bytes 8'hCD, 8'h20, 8'h30 -> 3 pulses; call_address=16'h3020; call_opcode_error=0. Repeat with first byte 8'h00 -> call_opcode_error=1 and call_address is still assembled.
- interrupt_enable=0 while INT is high for 20 cycles -> INTA# stays 1 and busy=0. Raising enable -> sequence starts 1 cycle later.
- Reset asserted during the second LOW phase -> INTA# returns to 1 asynchronously, vector_valid=0 and busy=0. After reset release with INT high, a fresh full sequence runs.
- INT dropped during the first GAP, and mode toggled mid-sequence -> sequence completes with the mode latched at start and vector_valid asserts.
- INT held high and vector_ready tied to 1 -> consecutive sequences with exactly one IDLE cycle between them; vector_valid pulses for 1 cycle each.
